// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one digit per cycle, least significant digit first.
// Latency: accept at edge k, result valid after edge k+DIGITS; one operation per DIGITS+2 cycles at most.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is high.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (a, b, cin, sub)
//   a, b                  BCD operands, digit i at [4i+3:4i]
//   cin                   carry-in (add) or borrow-in (sub)
//   sub                   0 = A+B+cin, 1 = A-B-cin
//   out_valid/out_ready   result handshake (sum, cout, err)
//   sum                   BCD result
//   cout                  carry-out (add) or no-borrow flag (sub)
//   err                   an operand digit was above 9
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sub_q;
    logic          carry;
    logic [IW-1:0] idx;

    logic          accept;
    logic          last_digit;
    logic          err_calc;
    logic [3:0]    a_dig;
    logic [3:0]    b_dig;
    logic [3:0]    bd;
    logic [4:0]    s;
    logic [3:0]    digit;
    logic          carry_nxt;

    assign accept     = in_valid && (state == IDLE);
    assign last_digit = (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_digit) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Any operand digit above 9, evaluated on the operands being accepted
    always_comb begin
        err_calc = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                err_calc = 1'b1;
            end
        end
    end

    // Select the current digit pair with constant part-selects
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
    end

    // Nines-complement of B for subtraction; wraps modulo 16 for invalid
    // digits so the result stays deterministic. Subtraction seeds the carry
    // with ~borrow, turning nines-complement into tens-complement.
    always_comb begin
        bd        = sub_q ? (4'd9 - b_dig) : b_dig;
        s         = {1'b0, a_dig} + {1'b0, bd} + {4'd0, carry};
        digit     = s[3:0];
        carry_nxt = 1'b0;
        if (s > 5'd9) begin
            digit     = 4'(s + 5'd6);
            carry_nxt = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            err   <= err_calc;
            carry <= sub ? ~cin : cin;
            idx   <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IW'(i)) begin
                    sum[4*i +: 4] <= digit;
                end
            end
            carry <= carry_nxt;
            if (last_digit) begin
                cout <= carry_nxt;
                idx  <= '0;
            end else begin
                idx  <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int vectors    = 0;
    int miscompares = 0;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one operation end to end. hold = cycles to keep out_ready low in
    // DONE; a spurious in_valid with different operands is pulsed during the hold.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input logic tsub, input logic [W-1:0] esum,
                          input logic ecout, input logic eerr, input int hold);
        int cyc;
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = '1;
        b        = '1;
        cin      = 1'b1;
        sub      = ~tsub;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            if (in_ready !== 1'b0) chk({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(DIGITS));
        chk({tag, ".sum"},  32'(sum),  32'(esum));
        chk({tag, ".cout"}, 32'(cout), 32'(ecout));
        chk({tag, ".err"},  32'(err),  32'(eerr));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_sum"},   32'(sum),       32'(esum));
            chk({tag, ".hold_cout"},  32'(cout),      32'(ecout));
            chk({tag, ".hold_rdy"},   32'(in_ready),  32'd0);
            if (i == 2) begin
                a        = 16'h9999;
                b        = 16'h9999;
                sub      = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_idle"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_after"}, 32'(in_ready),  32'd1);
        chk({tag, ".sum_idle"},       32'(sum),       32'(esum));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        #1;
        chk("reset.in_ready",  32'(in_ready),  32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.sum",       32'(sum),       32'd0);
        chk("reset.cout",      32'(cout),      32'd0);
        chk("reset.err",       32'(err),       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add1",     16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 0);
        run_op("add_wrap", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("add_cin",  16'h9999, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("sub_pos",  16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0, 0);
        run_op("sub_neg",  16'h1234, 16'h5000, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0, 0);
        run_op("sub_bin",  16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0998, 1'b1, 1'b0, 0);
        run_op("sub_zero", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
        run_op("add_cin2", 16'h0456, 16'h0544, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 0);
        run_op("err_a",    16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 0);
        run_op("err_b",    16'h0000, 16'h000F, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 0);
        run_op("hold",     16'h2468, 16'h1357, 1'b0, 1'b0, 16'h3825, 1'b0, 1'b0, 10);

        // Reset in the middle of RUN, after two digits have been processed
        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.in_ready",  32'(in_ready),  32'd1);
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.sum",       32'(sum),       32'd0);
        chk("midrst.cout",      32'(cout),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 16'h0789, 16'h0211, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
